// File: rtl/mac_result_unpacker.sv
// mac_result_unpacker: drains a packed Single/Dual/Quad accumulator word as one lane per beat.
// Define MAC_UNPACK_SIGN_EXT_EN to sign-extend narrow lanes instead of zero-extending them.
`ifndef MAC_INT_WIDTH
`define MAC_INT_WIDTH 32
`endif
`ifndef MAC_CONF_WIDTH
`define MAC_CONF_WIDTH 2
`endif
`ifndef MAC_SINGLE
`define MAC_SINGLE 2'd0
`endif
`ifndef MAC_DUAL
`define MAC_DUAL 2'd1
`endif
`ifndef MAC_QUAD
`define MAC_QUAD 2'd2
`endif

module mac_result_unpacker #(
    parameter bit LANE_MSB_FIRST = 1'b0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [`MAC_INT_WIDTH-1:0]  in_data,
    input  logic [`MAC_CONF_WIDTH-1:0] in_cfg,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [`MAC_INT_WIDTH-1:0]  out_data,
    output logic [1:0]                 out_lane,
    output logic                       out_last,
    output logic                       cfg_err
);
    localparam int IW = `MAC_INT_WIDTH;
`ifdef MAC_UNPACK_SIGN_EXT_EN
    localparam bit SEXT = 1'b1;
`else
    localparam bit SEXT = 1'b0;
`endif

    typedef enum logic {IDLE, DRAIN} state_t;

    state_t        state_q;
    logic [IW-1:0] data_q, out_data_q;
    logic [1:0]    nm1_q, cnt_q, out_lane_q;
    logic          out_valid_q, out_last_q, cfg_err_q;
    logic [1:0]    in_nm1, nxt;
    logic          cfg_ok, last_beat, in_hs, load, out_hs;

    // Lane count is kept as N-1 so that it doubles as the width selector.
    function automatic logic [1:0] lane_idx(input logic [1:0] nm1, input logic [1:0] cnt);
        return LANE_MSB_FIRST ? nm1 - cnt : cnt;
    endfunction

    function automatic logic [IW-1:0] lane_val(input logic [IW-1:0] d, input logic [1:0] nm1,
                                               input logic [1:0] k);
        logic [IW-1:0] s;
        s = d >> (int'(k) * (nm1 == 2'd3 ? IW / 4 : IW / 2));
        return nm1 == 2'd3 ? {{(IW - IW / 4){SEXT & s[IW/4-1]}}, s[IW/4-1:0]} :
               nm1 == 2'd1 ? {{(IW - IW / 2){SEXT & s[IW/2-1]}}, s[IW/2-1:0]} : s;
    endfunction

    assign cfg_ok    = in_cfg[1:0] == `MAC_SINGLE || in_cfg[1:0] == `MAC_DUAL ||
                       in_cfg[1:0] == `MAC_QUAD;
    assign in_nm1    = in_cfg[1:0] == `MAC_QUAD ? 2'd3 : in_cfg[1:0] == `MAC_DUAL ? 2'd1 : 2'd0;
    assign last_beat = cnt_q == nm1_q;
    assign in_ready  = !rst && (state_q == IDLE || (last_beat && out_ready));
    assign in_hs     = in_valid && in_ready;
    assign load      = in_hs && cfg_ok;
    assign out_hs    = out_valid_q && out_ready;
    assign nxt       = cnt_q + 2'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            data_q      <= '0;
            nm1_q       <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_lane_q  <= '0;
            out_last_q  <= 1'b0;
            cfg_err_q   <= 1'b0;
        end else begin
            cfg_err_q <= in_hs && !cfg_ok;
            if (load) begin
                state_q     <= DRAIN;
                data_q      <= in_data;
                nm1_q       <= in_nm1;
                cnt_q       <= '0;
                out_valid_q <= 1'b1;
                out_data_q  <= lane_val(in_data, in_nm1, lane_idx(in_nm1, 2'd0));
                out_lane_q  <= lane_idx(in_nm1, 2'd0);
                out_last_q  <= in_nm1 == 2'd0;
            end else if (out_hs && last_beat) begin
                state_q     <= IDLE;
                cnt_q       <= '0;
                out_valid_q <= 1'b0;
                out_last_q  <= 1'b0;
            end else if (out_hs) begin
                cnt_q       <= nxt;
                out_data_q  <= lane_val(data_q, nm1_q, lane_idx(nm1_q, nxt));
                out_lane_q  <= lane_idx(nm1_q, nxt);
                out_last_q  <= nxt == nm1_q;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_lane  = out_lane_q;
    assign out_last  = out_last_q;
    assign cfg_err   = cfg_err_q;
endmodule

// File: doc/mac_result_unpacker.md
# mac_result_unpacker

Result-side drain for the MAC array. It accepts one packed `MAC_INT_WIDTH` accumulator word per transaction, tagged with its Single/Dual/Quad configuration. It splits the word into 1, 2 or 4 independent lane results and emits them one lane per beat over a valid/ready stream to the writeback path. It is the consumer counterpart of the lane-combining done in the multiply blocks: packing happens there, unpacking happens here.

## Interface
- `LANE_MSB_FIRST`, default 0: 0 emits lane 0 (LSBs) first; 1 emits the highest lane first.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  packed word and cfg are presented.
- `in_ready`  out  1  unpacker can take a word this cycle.
- `in_data`  in  `MAC_INT_WIDTH`  packed accumulator word.
- `in_cfg`  in  `MAC_CONF_WIDTH`  mode; only bits [1:0] are decoded (`MAC_SINGLE` / `MAC_DUAL` / `MAC_QUAD`).
- `out_valid`  out  1  lane result is presented.
- `out_ready`  in  1  downstream accepts the beat.
- `out_data`  out  `MAC_INT_WIDTH`  lane result, extended to full width.
- `out_lane`  out  2  index of the lane carried in this beat.
- `out_last`  out  1  final beat of the current word.
- `cfg_err`  out  1  one-cycle pulse when a word with an undecodable cfg is accepted.

## Operation
- Lane width W is `MAC_INT_WIDTH` for Single, `MAC_INT_WIDTH`/2 for Dual and `MAC_INT_WIDTH`/4 for Quad. Lane k is `in_data[k*W +: W]`.
- Lane count N is 1, 2 or 4 for the three modes.
- Extension: `out_data` is the lane zero-extended to `MAC_INT_WIDTH` (see Configuration).
- FSM has two states:
  - IDLE: `in_ready`=1. On an input handshake with a valid cfg, register `in_data`, the decoded N and W, and lane counter = 0, then go to DRAIN.
  - DRAIN: `out_valid`=1. On an output handshake, increment the counter. On the handshake where counter = N-1, `out_last`=1 and the FSM returns to IDLE, unless a new word is accepted in the same cycle (see below).
- `out_lane` is the counter value when `LANE_MSB_FIRST`=0, and N-1-counter when `LANE_MSB_FIRST`=1.
- Undecodable cfg (bits [1:0] not one of the three modes):
  - the word is accepted, `cfg_err` pulses in the next cycle, no beats are emitted, and the FSM stays in IDLE.
- Back-to-back words:
  - `in_ready` is also 1 in DRAIN when counter = N-1 and `out_ready`=1 (combinational path from `out_ready`).
  - A word accepted that cycle loads directly and the FSM stays in DRAIN; there is no bubble.
- Stall: while `out_valid`=1 and `out_ready`=0, `out_data`, `out_lane` and `out_last` hold stable.
- `in_data` and `in_cfg` are sampled only on the input handshake. Changes at other times are ignored.

## Timing
- Reset values: state IDLE, counter 0, `out_valid`=0, `out_data`=0, `out_lane`=0, `out_last`=0, `cfg_err`=0.
- `in_ready` is forced to 0 while `rst`=1.
- Reset mid-drain discards the held word and any beats not yet emitted. The first cycle after reset is IDLE.
- Latency: input handshake in cycle T gives the first beat with `out_valid`=1 in cycle T+1.
- Throughput with `out_ready` held at 1:
  - Single: 1 word per cycle.
  - Dual: 1 word per 2 cycles.
  - Quad: 1 word per 4 cycles.
- `out_*` are registered outputs. `in_ready` is combinational from state, counter and `out_ready`.

## Configuration
- `MAC_UNPACK_SIGN_EXT_EN`:
  - Defined: each lane is sign-extended from bit W-1 to `MAC_INT_WIDTH`.
  - Undefined: lanes are zero-extended.
- Single mode is unaffected by the macro, since W = `MAC_INT_WIDTH`.

## Test plan
The bench builds with `MAC_MIN_WIDTH`=8, `MAC_INT_WIDTH`=32 and `LANE_MSB_FIRST`=0 unless stated otherwise.

- Single: word 0xDEADBEEF, `out_ready`=1 -> one beat 0xDEADBEEF, lane 0, last=1, in cycle T+1. A second word presented in the same cycle is accepted and emitted at T+2.
- Quad, zero-extend: word 0x80FF7F01 -> beats 0x01, 0x7F, 0xFF, 0x80 on lanes 0..3, last only on lane 3. With `MAC_UNPACK_SIGN_EXT_EN` defined -> 0x00000001, 0x0000007F, 0xFFFFFFFF, 0xFFFFFF80.
- Dual with `LANE_MSB_FIRST`=1: word 0x12345678 -> 0x1234 on lane 1, then 0x5678 on lane 0 with last=1.
- Backpressure: Quad word, `out_ready` low for 3 cycles on lane 2 -> lane 2 data held stable, `in_ready`=0 throughout, and all 4 beats still delivered in order.
- Bad cfg (bits [1:0] undecodable) -> `cfg_err`=1 for exactly one cycle, no `out_valid`, and a following valid word is processed normally.
- `rst` asserted after lane 1 of a Quad word -> `out_valid`=0 the next cycle, no remaining lanes emitted, and a new word unpacks correctly.
